ps2_transmitter: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset) to the keyboard.

---
 rtl/ps2_transmitter.sv | 250 +++++++++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command transmitter.
//   Runs inhibit -> start -> 8 data bits (LSB first) -> odd parity -> stop
//   -> device ACK on open-drain kclk/kdata, with a frame timeout.
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   tx_data, tx_valid   command byte and request (accepted when tx_ready)
//   tx_ready            high only in IDLE (returns the cycle after done/err)
//   kclk_in, kdata_in   raw PS/2 line levels (asynchronous)
//   kclk_oe, kdata_oe   1 = pull line low, 0 = release
//   busy                high whenever a frame is in progress
//   done, err           one-cycle result pulses (never together)
module ps2_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned FILTER_CYCLES  = 19,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned FLT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BIT_W = 4;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [FLT_W-1:0] FLT_MAX  = FLT_W'(FILTER_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(8);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    STOP,
    ACK,
    WAIT_IDLE
  } state_e;

  // Line conditioning: index 0 = kclk, index 1 = kdata
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       filt_q, filt_d;
  logic [FLT_W-1:0] fcnt_q [2];
  logic [FLT_W-1:0] fcnt_d [2];
  logic             kclk_dly_q;
  logic             fall_c;

  // Frame control
  state_e           state_q, state_d;
  logic [8:0]       sr_q, sr_d;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             kclk_oe_q, kclk_oe_d;
  logic             kdata_oe_q, kdata_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             active_c;
  logic             timeout_c;

  // Two-flop synchronizers and filter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      kclk_dly_q <= 1'b1;
    end else begin
      sync1_q    <= {kdata_in, kclk_in};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      fcnt_q[0]  <= fcnt_d[0];
      fcnt_q[1]  <= fcnt_d[1];
      kclk_dly_q <= filt_q[0];
    end
  end

  // Filter: adopt the synced level after FILTER_CYCLES+1 consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FLT_MAX) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + FLT_W'(1);
        end
      end
    end
  end

  assign fall_c = kclk_dly_q & ~filt_q[0];

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bitcnt_q   <= '0;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      kclk_oe_q  <= 1'b0;
      kdata_oe_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bitcnt_q   <= bitcnt_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      kclk_oe_q  <= kclk_oe_d;
      kdata_oe_q <= kdata_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Device-clocked phase: the timeout window runs from clock release to the end
  assign active_c  = (state_q == SEND) || (state_q == STOP) ||
                     (state_q == ACK)  || (state_q == WAIT_IDLE);
  assign timeout_c = active_c && (tmo_cnt_q == TMO_LAST);

  // Next-state and line-drive logic
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bitcnt_d   = bitcnt_q;
    inh_cnt_d  = inh_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    kclk_oe_d  = kclk_oe_q;
    kdata_oe_d = kdata_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (active_c) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    if (timeout_c) begin
      // Timeout takes priority over any edge seen in the same cycle
      kclk_oe_d  = 1'b0;
      kdata_oe_d = 1'b0;
      err_d      = 1'b1;
      state_d    = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          kclk_oe_d  = 1'b0;
          kdata_oe_d = 1'b0;
          if (tx_valid && tx_ready_q) begin
            sr_d      = {~^tx_data, tx_data};
            bitcnt_d  = '0;
            inh_cnt_d = '0;
            kclk_oe_d = 1'b1;
            state_d   = INHIBIT;
          end
        end

        INHIBIT: begin
          // Clock is ours here, so falls are ignored
          inh_cnt_d = inh_cnt_q + INH_W'(1);
          if (inh_cnt_q == INH_PRE) begin
            kdata_oe_d = 1'b1;
          end
          if (inh_cnt_q == INH_LAST) begin
            kclk_oe_d  = 1'b0;
            kdata_oe_d = 1'b1;
            tmo_cnt_d  = '0;
            state_d    = SEND;
          end
        end

        SEND: begin
          if (fall_c) begin
            kdata_oe_d = ~sr_q[0];
            sr_d       = {1'b0, sr_q[8:1]};
            bitcnt_d   = bitcnt_q + BIT_W'(1);
            if (bitcnt_q == BIT_LAST) begin
              state_d = STOP;
            end
          end
        end

        STOP: begin
          if (fall_c) begin
            kdata_oe_d = 1'b0;
            state_d    = ACK;
          end
        end

        ACK: begin
          if (fall_c) begin
            if (!filt_q[1]) begin
              state_d = WAIT_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          if (filt_q == 2'b11) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end

        default: begin
          kclk_oe_d  = 1'b0;
          kdata_oe_d = 1'b0;
          state_d    = IDLE;
        end
      endcase
    end

    // tx_ready reopens one cycle after the result pulse
    tx_ready_d = (state_d == IDLE) && !done_d && !err_d;
    busy_d     = (state_d != IDLE);
  end

  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign kclk_oe  = kclk_oe_q;
  assign kdata_oe = kdata_oe_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: PS/2 device model and scoreboard for ps2_transmitter.
module tb_ps2_transmitter;

  localparam int unsigned INH  = 40;
  localparam int unsigned FLT  = 4;
  localparam int unsigned TMO  = 3000;
  localparam int          HALF = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       kclk_oe, kdata_oe;
  logic       busy, done, err;
  logic       dev_clk_low, dev_data_low;
  wire        kclk_line  = ~(kclk_oe | dev_clk_low);
  wire        kdata_line = ~(kdata_oe | dev_data_low);

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int acc_cnt = 0;

  logic [10:0] exp_frame_q [$];
  int          exp_res_q   [$];

  always #5 clk = ~clk;

  ps2_transmitter #(
    .INHIBIT_CYCLES(INH),
    .FILTER_CYCLES (FLT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .kclk_in (kclk_line),
    .kdata_in(kdata_line),
    .kclk_oe (kclk_oe),
    .kdata_oe(kdata_oe),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Result pulse monitor
  always @(negedge clk) begin
    if (done || err) begin
      chk("done_err_exclusive", int'(done & err), 0);
      done_cnt += int'(done);
      err_cnt  += int'(err);
    end
  end

  // Inputs change only at negedge, so they are stable here
  always @(posedge clk) begin
    if (tx_valid && tx_ready) acc_cnt++;
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Request a frame and check the inhibit/start sequence up to clock release
  task automatic start_tx(input logic [7:0] b, input bit hold, input bit push, input int exp_res);
    int n;
    logic prev, prev2;
    n = 0;
    while (!tx_ready && n < 1000) begin tick(); n++; end
    chk("ready_before_req", int'(tx_ready), 1);
    if (push) begin
      exp_frame_q.push_back(exp_frame(b));
      exp_res_q.push_back(exp_res);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    if (!hold) begin
      tx_valid = 1'b0;
      tx_data  = ~b;
    end
    chk("busy_after_accept", int'(busy), 1);
    chk("kclk_oe_inhibit", int'(kclk_oe), 1);
    chk("kdata_oe_inhibit", int'(kdata_oe), 0);
    n = 1;
    prev = 1'b0;
    prev2 = 1'b0;
    while (kclk_oe && n < int'(INH) + 10) begin
      prev2 = prev;
      prev  = kdata_oe;
      tick();
      n++;
    end
    chk("release_latency", n, int'(INH) + 1);
    chk("start_bit_at_release", int'(kdata_oe), 1);
    chk("start_bit_last_inhibit", int'(prev), 1);
    chk("data_free_before_last", int'(prev2), 0);
  endtask

  // Device: generates n_clk clocks, samples data on rising edges, optional ACK and glitch
  task automatic dev_clock(input int n_clk, input bit ack_low, input int glitch_at,
                           output logic [10:0] bits);
    bits = '1;
    ticks(HALF);
    bits[0] = kdata_line;
    for (int k = 1; k <= n_clk; k++) begin
      dev_clk_low = 1'b1;
      ticks(HALF);
      if (k <= 10) bits[k] = kdata_line;
      dev_clk_low = 1'b0;
      if (k == 10 && ack_low) dev_data_low = 1'b1;
      if (k == glitch_at) begin
        ticks(HALF / 2);
        dev_clk_low = 1'b1;
        ticks(2);
        dev_clk_low = 1'b0;
        ticks(HALF - HALF / 2 - 2);
      end else begin
        ticks(HALF);
      end
    end
    dev_data_low = 1'b0;
  endtask

  // Full frame through the scoreboard: expected frame/result pushed at request time
  task automatic do_frame(input logic [7:0] b, input bit ack_low, input int glitch_at,
                          input bit hold);
    logic [10:0] bits;
    logic [10:0] ef;
    int d0, e0, a0, n, er;
    d0 = done_cnt;
    e0 = err_cnt;
    a0 = acc_cnt;
    start_tx(b, hold, 1'b1, ack_low ? 0 : 1);
    dev_clock(11, ack_low, glitch_at, bits);
    n = 0;
    while ((done_cnt + err_cnt) == (d0 + e0) && !done && !err && n < 200) begin
      tick();
      n++;
    end
    tx_valid = 1'b0;
    chk("result_seen", int'(n < 200), 1);
    ticks(3);
    ef = exp_frame_q.pop_front();
    er = exp_res_q.pop_front();
    chk("frame_bits", int'(bits), int'(ef));
    chk("done_pulses", done_cnt - d0, (er == 0) ? 1 : 0);
    chk("err_pulses", err_cnt - e0, (er == 1) ? 1 : 0);
    chk("accepts", acc_cnt - a0, 1);
    chk("idle_ready", int'(tx_ready), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_lines", int'({kclk_oe, kdata_oe}), 0);
  endtask

  initial begin
    logic [10:0] junk;
    int n;
    rst_n        = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    ticks(3);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lines", int'({kclk_oe, kdata_oe}), 0);
    chk("rst_pulses", int'({done, err}), 0);
    rst_n = 1'b1;
    ticks(10);

    // Normal frames, including both parity polarities
    do_frame(8'hED, 1'b1, 0, 1'b0);
    do_frame(8'h00, 1'b1, 0, 1'b0);
    do_frame(8'hFF, 1'b1, 0, 1'b0);

    // Device leaves data high at the ACK clock
    do_frame(8'hA5, 1'b0, 0, 1'b0);

    // Device never clocks: timeout exactly TMO cycles after release
    begin
      int e0;
      e0 = err_cnt;
      start_tx(8'h12, 1'b0, 1'b0, 1);
      n = 0;
      while (!err && n < int'(TMO) + 50) begin tick(); n++; end
      chk("timeout_cycles", n, int'(TMO));
      chk("timeout_lines", int'({kclk_oe, kdata_oe}), 0);
      chk("timeout_no_done", int'(done), 0);
      tick();
      chk("timeout_ready", int'(tx_ready), 1);
      chk("timeout_err_once", err_cnt - e0, 1);
    end
    ticks(10);

    // Reset after the 4th data bit, then a clean frame
    start_tx(8'h3C, 1'b0, 1'b0, 0);
    dev_clock(4, 1'b0, 0, junk);
    chk("mid_frame_busy", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_lines", int'({kclk_oe, kdata_oe}), 0);
    chk("midrst_busy", int'(busy), 0);
    rst_n = 1'b1;
    ticks(10);
    do_frame(8'hF4, 1'b1, 0, 1'b0);

    // tx_valid held through a frame with a short clock glitch
    do_frame(8'h55, 1'b1, 3, 1'b1);
    ticks(5);
    chk("no_second_frame", int'(busy), 0);

    chk("scoreboard_empty", exp_frame_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
